// File: rtl/knn_pkg.sv
// Shared definitions for the KNN host driver and the accelerator controller.
package knn_pkg;

    // Train points required before the accelerator starts sorting.
    localparam int NUM_TRAIN_DEF = 128;

    // Host command encoding carried on h_cmd.
    typedef enum logic [1:0] {
        CMD_TRAIN  = 2'b00,
        CMD_TEST   = 2'b01,
        CMD_UPDATE = 2'b10,
        CMD_RSVD   = 2'b11
    } host_cmd_e;

    // Driver sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_RESULT = 2'd1,
        ST_RESULT_OUT  = 2'd2,
        ST_FINISHED    = 2'd3
    } drv_state_e;

endpackage

// File: rtl/knn_host_driver_if.sv
// Host command/result handshakes plus the accelerator control bus.
// master = the driver, slave = host adapter and accelerator side.
interface knn_host_driver_if #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 8
);
    logic              h_valid;
    logic              h_ready;
    logic [1:0]        h_cmd;
    logic [DATA_W-1:0] h_data;

    logic              knn_valid;
    logic              knn_data_type;
    logic              knn_train_points_update;
    logic [DATA_W-1:0] knn_data;
    logic              knn_busy;
    logic              knn_result_valid;
    logic [RES_W-1:0]  knn_result;

    logic              r_valid;
    logic              r_ready;
    logic [RES_W-1:0]  r_data;

    logic [7:0]        o_train_count;
    logic              o_timeout;

    modport master (
        input  h_valid, h_cmd, h_data, knn_busy, knn_result_valid, knn_result, r_ready,
        output h_ready, knn_valid, knn_data_type, knn_train_points_update, knn_data,
               r_valid, r_data, o_train_count, o_timeout
    );

    modport slave (
        output h_valid, h_cmd, h_data, knn_busy, knn_result_valid, knn_result, r_ready,
        input  h_ready, knn_valid, knn_data_type, knn_train_points_update, knn_data,
               r_valid, r_data, o_train_count, o_timeout
    );

endinterface

// File: rtl/knn_host_driver.sv
// Host-side driver for the KNN accelerator: turns host commands into
// single-cycle accelerator pulses and hands the classification result back.
module knn_host_driver
    import knn_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int RES_W       = 8,
    parameter int NUM_TRAIN   = NUM_TRAIN_DEF,
    parameter int TIMEOUT_CYC = 256
) (
    input logic               clk,
    input logic               rst,
    knn_host_driver_if.master bus
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_WAIT   = ST_WAIT_RESULT;
    localparam logic [1:0] S_RESULT = ST_RESULT_OUT;
    localparam logic [1:0] S_FIN    = ST_FINISHED;

    localparam int         TW  = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [7:0] NT8 = 8'(NUM_TRAIN);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              seen_q, seen_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              tflag_q, tflag_d;
    logic              rv_q, rv_d;
    logic [RES_W-1:0]  rd_q, rd_d;
    logic              kv_q, kv_d;
    logic              kt_q, kt_d;
    logic              ku_q, ku_d;
    logic [DATA_W-1:0] kd_q, kd_d;
    logic              rdy_q, rdy_d;
    logic              acc, enter_wait;

    // Next-state: command decode, result capture, timeout and ready generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        seen_d     = seen_q;
        tmo_d      = tmo_q;
        tflag_d    = tflag_q;
        rv_d       = rv_q;
        rd_d       = rd_q;
        kv_d       = 1'b0;
        kt_d       = 1'b0;
        ku_d       = 1'b0;
        kd_d       = kd_q;
        enter_wait = 1'b0;
        acc        = bus.h_valid & rdy_q;

        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    case (bus.h_cmd)
                        CMD_TRAIN: begin
                            kv_d = 1'b1;
                            kd_d = bus.h_data;
                            if (cnt_q < NT8) cnt_d = cnt_q + 8'd1;
                        end
                        CMD_TEST: begin
                            kv_d   = 1'b1;
                            kt_d   = 1'b1;
                            kd_d   = bus.h_data;
                            pend_d = 1'b1;
                        end
                        CMD_UPDATE: begin
                            ku_d   = 1'b1;
                            cnt_d  = 8'd0;
                            pend_d = 1'b0;
                        end
                        default: ;
                    endcase
                    // Either order works: whichever pulse completes the set starts the wait.
                    if (kv_d && cnt_d == NT8 && pend_d) enter_wait = 1'b1;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.knn_busy) seen_d = 1'b1;
                // Only trust result_valid once busy has been seen; before that it is the
                // previous run's finished-state valid.
                if (bus.knn_result_valid && seen_q) begin
                    rv_d    = 1'b1;
                    rd_d    = bus.knn_result;
                    state_d = S_RESULT;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    tflag_d = 1'b1;
                    cnt_d   = 8'd0;
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RESULT: begin
                if (rv_q && bus.r_ready) begin
                    rv_d    = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (acc) begin
                    case (bus.h_cmd)
                        CMD_TRAIN: begin
                            kv_d       = 1'b1;
                            kd_d       = bus.h_data;
                            enter_wait = 1'b1;
                        end
                        CMD_TEST: begin
                            kv_d       = 1'b1;
                            kt_d       = 1'b1;
                            kd_d       = bus.h_data;
                            pend_d     = 1'b1;
                            enter_wait = 1'b1;
                        end
                        CMD_UPDATE: begin
                            ku_d    = 1'b1;
                            cnt_d   = 8'd0;
                            pend_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_wait) begin
            state_d = S_WAIT;
            seen_d  = 1'b0;
            tmo_d   = '0;
        end

        rdy_d = (state_d == S_IDLE || state_d == S_FIN) && !rv_d && !bus.knn_busy;
    end

    // State and output registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            seen_q  <= 1'b0;
            tmo_q   <= '0;
            tflag_q <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            kv_q    <= 1'b0;
            kt_q    <= 1'b0;
            ku_q    <= 1'b0;
            kd_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            seen_q  <= seen_d;
            tmo_q   <= tmo_d;
            tflag_q <= tflag_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            kv_q    <= kv_d;
            kt_q    <= kt_d;
            ku_q    <= ku_d;
            kd_q    <= kd_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.h_ready                 = rdy_q;
    assign bus.knn_valid               = kv_q;
    assign bus.knn_data_type           = kt_q;
    assign bus.knn_train_points_update = ku_q;
    assign bus.knn_data                = kd_q;
    assign bus.r_valid                 = rv_q;
    assign bus.r_data                  = rd_q;
    assign bus.o_train_count           = cnt_q;
    assign bus.o_timeout               = tflag_q;

endmodule

// File: tb/tb_knn_host_driver.sv
// Directed/randomized bench for knn_host_driver with a count/pending reference model.
`timescale 1ns/1ps
module tb_knn_host_driver;
    import knn_pkg::*;

    localparam int DW = 16;
    localparam int RW = 8;
    localparam int NT = 128;
    localparam int TO = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    knn_host_driver_if #(.DATA_W(DW), .RES_W(RW)) bus();

    knn_host_driver #(.DATA_W(DW), .RES_W(RW), .NUM_TRAIN(NT), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int upd_pulses = 0;

    // Reference model: train points since last update (saturating) and test-pending flag.
    int m_cnt = 0;
    bit m_pend = 1'b0;

    always @(posedge clk) begin
        if (bus.knn_valid === 1'b1) pulses <= pulses + 1;
        if (bus.knn_train_points_update === 1'b1) upd_pulses <= upd_pulses + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle-side readiness predicted from the model: ready unless the set is complete.
    function automatic logic exp_ready();
        return !(m_cnt == NT && m_pend);
    endfunction

    // Back-to-back train burst; checks every pulse, its payload, ready and the count.
    task automatic train_burst(input int n, input string tag);
        int bad;
        logic [DW-1:0] cur;
        bad = 0;
        cur = DW'($urandom);
        bus.h_valid = 1'b1;
        bus.h_cmd   = CMD_TRAIN;
        bus.h_data  = cur;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (m_cnt < NT) m_cnt++;
            if (bus.knn_valid !== 1'b1 || bus.knn_data_type !== 1'b0 || bus.knn_data !== cur ||
                bus.h_ready !== exp_ready() || bus.o_train_count !== 8'(m_cnt)) bad++;
            cur = DW'($urandom);
            if (i < n - 1) bus.h_data = cur;
            else bus.h_valid = 1'b0;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic send_one(input logic [1:0] cmd, input logic [DW-1:0] d);
        bus.h_valid = 1'b1;
        bus.h_cmd   = cmd;
        bus.h_data  = d;
        @(negedge clk);
        bus.h_valid = 1'b0;
    endtask

    task automatic wait_rvalid();
        for (int k = 0; k < 20; k++) begin
            if (bus.r_valid === 1'b1) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int p0, u0, bad;
        logic [DW-1:0] d;

        bus.h_valid = 1'b0; bus.h_cmd = 2'b00; bus.h_data = '0;
        bus.knn_busy = 1'b0; bus.knn_result_valid = 1'b0; bus.knn_result = '0;
        bus.r_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_flags", 32'({bus.h_ready, bus.knn_valid, bus.knn_data_type, bus.knn_train_points_update,
                              bus.r_valid, bus.o_timeout}), 32'd0);
        chk("rst_count", 32'(bus.o_train_count), 32'd0);
        chk("rst_rdata", 32'(bus.r_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.h_ready), 32'd1);

        // 1: 128 trains then a test, result delivered after busy phase
        p0 = pulses;
        train_burst(NT, "s1_train_stream");
        chk("s1_count_full", 32'(bus.o_train_count), 32'd128);
        d = DW'($urandom);
        send_one(CMD_TEST, d);
        m_pend = 1'b1;
        chk("s1_test_pulse", 32'({bus.knn_valid, bus.knn_data_type}), 32'd3);
        chk("s1_test_data", 32'(bus.knn_data), 32'(d));
        chk("s1_ready_drop", 32'(bus.h_ready), 32'(exp_ready()));
        @(negedge clk);
        chk("s1_pulse_total", 32'(pulses - p0), 32'd129);
        chk("s1_pulse_single", 32'(bus.knn_valid), 32'd0);
        bus.knn_busy = 1'b1;
        repeat (33) @(negedge clk);
        chk("s1_busy_hold", 32'({bus.h_ready, bus.r_valid}), 32'd0);
        bus.knn_busy = 1'b0; bus.knn_result_valid = 1'b1; bus.knn_result = 8'h5A;
        @(negedge clk);
        wait_rvalid();
        chk("s1_rvalid", 32'(bus.r_valid), 32'd1);
        chk("s1_rdata", 32'(bus.r_data), 32'h5A);
        bus.knn_result = 8'h00;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.r_valid !== 1'b1 || bus.r_data !== 8'h5A || bus.h_ready !== 1'b0) bad++;
        end
        chk("s1_result_stable", 32'(bad), 32'd0);
        bus.r_ready = 1'b1;
        @(negedge clk);
        bus.r_ready = 1'b0;
        chk("s1_consumed", 32'({bus.r_valid, bus.h_ready}), 32'd1);

        // 3: test from FINISHED while stale result_valid is high
        d = DW'($urandom);
        send_one(CMD_TEST, d);
        chk("s3_test_pulse", 32'({bus.knn_valid, bus.knn_data_type}), 32'd3);
        chk("s3_test_data", 32'(bus.knn_data), 32'(d));
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.r_valid !== 1'b0) bad++;
        end
        chk("s3_no_stale_capture", 32'(bad), 32'd0);
        bus.knn_busy = 1'b1; bus.knn_result_valid = 1'b0;
        @(negedge clk);
        bus.knn_busy = 1'b0; bus.knn_result_valid = 1'b1; bus.knn_result = 8'h11;
        @(negedge clk);
        wait_rvalid();
        chk("s3_rvalid", 32'(bus.r_valid), 32'd1);
        chk("s3_rdata", 32'(bus.r_data), 32'h11);
        bus.r_ready = 1'b1;
        @(negedge clk);
        bus.r_ready = 1'b0;
        chk("s3_consumed", 32'(bus.r_valid), 32'd0);

        // 4: update from FINISHED, then a lone test stays in IDLE
        u0 = upd_pulses;
        send_one(CMD_UPDATE, DW'($urandom));
        m_cnt = 0; m_pend = 1'b0;
        chk("s4_upd_pulse", 32'({bus.knn_train_points_update, bus.knn_valid}), 32'd2);
        chk("s4_count_clr", 32'(bus.o_train_count), 32'd0);
        chk("s4_ready", 32'(bus.h_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("s4_upd_once", 32'(upd_pulses - u0), 32'd1);
        d = DW'($urandom);
        send_one(CMD_TEST, d);
        m_pend = 1'b1;
        chk("s4_test_pulse", 32'({bus.knn_valid, bus.knn_data_type}), 32'd3);
        @(negedge clk);
        chk("s4_no_wait", 32'(bus.h_ready), 32'(exp_ready()));

        // 2: test already pending, 128 trains complete the set
        train_burst(NT, "s2_train_stream");
        chk("s2_count", 32'(bus.o_train_count), 32'd128);
        @(negedge clk);
        chk("s2_in_wait", 32'(bus.h_ready), 32'd0);

        // 6: reset during WAIT_RESULT while a result would be captured
        bus.r_ready = 1'b1; bus.knn_busy = 1'b1;
        @(negedge clk);
        bus.knn_busy = 1'b0; bus.knn_result_valid = 1'b1; bus.knn_result = 8'h77; rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_flags", 32'({bus.h_ready, bus.knn_valid, bus.knn_data_type, bus.knn_train_points_update,
                                 bus.r_valid, bus.o_timeout}), 32'd0);
        chk("s6_rst_vals", 32'({bus.o_train_count, bus.r_data, bus.knn_data}), 32'd0);
        rst = 1'b0; bus.knn_result_valid = 1'b0;
        m_cnt = 0; m_pend = 1'b0;
        repeat (2) @(negedge clk);
        chk("s6_no_result", 32'({bus.r_valid, bus.h_ready}), 32'd1);
        bus.r_ready = 1'b0;

        // 2b/5: 129 trains saturate, then test, then timeout
        train_burst(NT + 1, "s5_train_saturate");
        chk("s5_count_sat", 32'(bus.o_train_count), 32'd128);
        d = DW'($urandom);
        send_one(CMD_TEST, d);
        m_pend = 1'b1;
        chk("s5_test_pulse", 32'({bus.knn_valid, bus.knn_data_type, bus.h_ready}), 32'd6);
        repeat (TO - 1) @(negedge clk);
        chk("s5_no_early_timeout", 32'({bus.o_timeout, bus.h_ready}), 32'd0);
        @(negedge clk);
        m_cnt = 0; m_pend = 1'b0;
        chk("s5_timeout", 32'(bus.o_timeout), 32'd1);
        chk("s5_count_clr", 32'(bus.o_train_count), 32'(m_cnt));
        chk("s5_idle_ready", 32'(bus.h_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("s5_sticky", 32'(bus.o_timeout), 32'd1);
        send_one(CMD_TEST, DW'($urandom));
        m_pend = 1'b1;
        chk("s5_test_after_to", 32'(bus.h_ready), 32'(exp_ready()));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("s5_rst_clears_to", 32'(bus.o_timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/knn_host_driver.md
Name: knn_host_driver

Overview:
Host-side driver for the KNN accelerator control interface: the transmitting end of the valid/data-type point protocol.
- Takes host commands (train point, test point, train-set update) over a ready/valid port.
- Serialises them into single-cycle accelerator pulses, respecting the accelerator's busy/finished sequencing.
- Captures the classification result when the accelerator signals completion and returns it over a ready/valid result port.
- Sits between the host bus adapter and the accelerator controller.

Parameters:
DATA_W, 16, width of a point word on host and accelerator data buses
RES_W, 8, width of the accelerator result word
NUM_TRAIN, 128, train points needed before sorting starts
TIMEOUT_CYC, 256, max cycles in WAIT_RESULT before timeout

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
h_valid  in  1  host command valid
h_ready  out  1  driver accepts command this cycle
h_cmd  in  2  00 train, 01 test, 10 update (new train set), 11 reserved
h_data  in  DATA_W  point payload
knn_valid  out  1  to accelerator i_valid
knn_data_type  out  1  0 train, 1 test
knn_train_points_update  out  1  to accelerator i_train_points_update
knn_data  out  DATA_W  point word to accelerator
knn_busy  in  1  accelerator o_busy
knn_result_valid  in  1  accelerator o_valid (high in its finished state)
knn_result  in  RES_W  accelerator result
r_valid  out  1  result available to host
r_ready  in  1  host consumes result
r_data  out  RES_W  captured result
o_train_count  out  8  train points sent since last update, saturating at NUM_TRAIN
o_timeout  out  1  sticky timeout flag

Behaviour:
- All outputs are registered. On rst, every output is 0, the state is IDLE, train_count=0 and test_pending=0. Reset wins over any simultaneous event, including mid-sort.
- States: IDLE, WAIT_RESULT, RESULT_OUT, FINISHED.
- Accept rule: a command is accepted on h_valid & h_ready. h_ready=1 only in IDLE or FINISHED, and only when r_valid=0 and knn_busy=0.
- Latency: an accepted command drives knn_valid/knn_data_type/knn_data for exactly one cycle, in the cycle after acceptance. Back-to-back commands give back-to-back pulses.
- IDLE behaviour:
  - train: pulse with type 0; train_count increments if below NUM_TRAIN, otherwise holds.
  - test: pulse with type 1; sets test_pending.
  - update: pulse knn_train_points_update; clear train_count and test_pending.
  - reserved: accepted and dropped; no pulse.
- IDLE -> WAIT_RESULT in the cycle a pulse leaves train_count==NUM_TRAIN with test_pending=1. This covers both orders: test first, then the 128th train; or the 128th train, then test.
- WAIT_RESULT:
  - seen_busy is cleared on entry and set when knn_busy=1.
  - knn_result_valid is ignored until seen_busy=1. This prevents capturing the stale finished-state valid.
  - When knn_result_valid=1 and seen_busy=1: capture knn_result into r_data, set r_valid, go to RESULT_OUT.
  - Cycle counter: if it reaches TIMEOUT_CYC, set o_timeout (cleared only by rst), clear train_count and test_pending, go to IDLE.
- RESULT_OUT: hold r_valid and r_data stable until r_ready; on r_valid & r_ready clear r_valid and go to FINISHED.
- FINISHED:
  - test: pulse type 1, go to WAIT_RESULT.
  - train: pulse type 0 (single-point replacement), count unchanged, go to WAIT_RESULT.
  - update: pulse knn_train_points_update for one cycle, clear train_count and test_pending, go to IDLE.
  - reserved: dropped, stay.
- Width rule: train_count is 8 bits; NUM_TRAIN must be at most 255.

Decomposition:
- Shared package knn_pkg holds: the host command enum (train/test/update/reserved), the driver state enum, and the NUM_TRAIN default constant shared with the accelerator controller.
- No sub-module is natural; the timeout counter and result register stay inline in a single flat module.

Test Plan:
1. 128 train cmds then 1 test -> 129 knn_valid pulses with data matching; 129th has type 1; h_ready drops; bench asserts knn_busy for 33 cycles then knn_result_valid with result 0x5A -> r_valid=1, r_data=0x5A; holds until r_ready.
2. Test cmd first, then 128 trains -> WAIT_RESULT entered in the cycle after the 128th pulse; o_train_count=128; a 129th train in IDLE before the test keeps the count at 128.
3. In FINISHED, a test cmd with knn_result_valid still high and knn_busy low for 2 cycles -> no capture; capture only after knn_busy has pulsed, then result 0x11 appears on r_data.
4. Update cmd in FINISHED -> exactly one knn_train_points_update pulse; o_train_count=0; state IDLE; the following test alone does not enter WAIT_RESULT.
5. No knn_busy or knn_result_valid for 256 cycles in WAIT_RESULT -> o_timeout=1 stays high; state IDLE; count 0; rst clears o_timeout.
6. rst asserted mid-WAIT_RESULT with r_ready high -> next cycle all outputs 0, state IDLE, no result delivered.
